pipe_hazard_ctrl: RTL and testbench

Hazard and exception controller for the five-stage pipeline. It produces the `stall`, `flush`, `illop` and `xadr` controls consumed by the ID/EX pipeline register, and the matching IF/ID flush, PC hold and PC-select controls. It detects load-use and `jr` dependences and taken branches. It synchronises and latches the external interrupt, sequences illegal-instruction and interrupt entry into the kernel handlers, and captures EPC.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and exception controller for the five-stage pipeline: load-use/jr stalls,
// taken-branch flush, illegal-instruction and interrupt entry with EPC capture.
module pipe_hazard_ctrl #(
   parameter int DRAIN_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  IDrs,
   input  logic [4:0]  IDrt,
   input  logic        IDUsesRs,
   input  logic        IDUsesRt,
   input  logic        IDJr,
   input  logic        IDIllegal,
   input  logic        IDValid,
   input  logic [31:0] IDPC,
   input  logic [4:0]  EXWriteReg,
   input  logic        EXRegWrite,
   input  logic        EXMemRead,
   input  logic [4:0]  MEMWriteReg,
   input  logic        MEMMemRead,
   input  logic        EXBranchTaken,
   input  logic        irq,
   output logic        stall,
   output logic        PCHold,
   output logic        flush,
   output logic        IFIDFlush,
   output logic        illop,
   output logic        xadr,
   output logic [1:0]  PCSel,
   output logic        EPCWrite,
   output logic [31:0] EPC
);
   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;
   localparam int CW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);

   logic [0:0]    state;
   logic [CW-1:0] drain_cnt;
   logic          s1, s2, s3, irq_pending;
   logic          lu, jh, hazard, user_id, irq_rise, drain_done;

   assign lu = EXMemRead && (EXWriteReg != 5'd0) &&
               ((IDUsesRs && (EXWriteReg == IDrs)) || (IDUsesRt && (EXWriteReg == IDrt)));
   // jr needs rs in ID, so an ALU result in EX or a load result in MEM is not yet usable
   assign jh = IDJr && (IDrs != 5'd0) &&
               ((EXRegWrite && (EXWriteReg == IDrs)) || (MEMMemRead && (MEMWriteReg == IDrs)));
   assign hazard     = lu || jh;
   assign user_id    = IDValid && !IDPC[31];
   assign irq_rise   = s2 && !s3;
   assign drain_done = (IDValid && IDPC[31]) || (drain_cnt >= CW'(DRAIN_MAX));

   always_comb begin
      stall     = 1'b0;
      PCHold    = 1'b0;
      flush     = 1'b0;
      IFIDFlush = 1'b0;
      illop     = 1'b0;
      xadr      = 1'b0;
      PCSel     = 2'b00;
      EPCWrite  = 1'b0;
      if (!reset) begin
         if (EXBranchTaken) begin
            flush     = 1'b1;
            IFIDFlush = 1'b1;
            PCSel     = 2'b01;
         end else if ((state == RUN) && IDIllegal && user_id && !hazard) begin
            illop     = 1'b1;
            IFIDFlush = 1'b1;
            EPCWrite  = 1'b1;
            PCSel     = 2'b11;
         end else if ((state == RUN) && irq_pending && user_id && !hazard) begin
            xadr      = 1'b1;
            IFIDFlush = 1'b1;
            EPCWrite  = 1'b1;
            PCSel     = 2'b10;
         end else if (hazard) begin
            stall  = 1'b1;
            PCHold = 1'b1;
         end
      end
   end

   // Edges arriving while an interrupt is already pending are absorbed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         s1 <= irq;
         s2 <= s1;
         s3 <= s2;
         if (xadr)
            irq_pending <= 1'b0;
         else if (irq_rise)
            irq_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         drain_cnt <= '0;
         EPC       <= 32'd0;
      end else if (illop || xadr) begin
         state     <= DRAIN;
         drain_cnt <= CW'(1);
         EPC       <= illop ? (IDPC + 32'd4) : IDPC;
      end else if (state == DRAIN) begin
         if (drain_done) begin
            state     <= RUN;
            drain_cnt <= '0;
         end else begin
            drain_cnt <= drain_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: behavioural model compared every cycle,
// plus hand-computed checkpoints for each scenario.
module tb_pipe_hazard_ctrl;
   localparam int DRAIN_MAX = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  IDrs, IDrt, EXWriteReg, MEMWriteReg;
   logic        IDUsesRs, IDUsesRt, IDJr, IDIllegal, IDValid;
   logic [31:0] IDPC;
   logic        EXRegWrite, EXMemRead, MEMMemRead, EXBranchTaken, irq;
   logic        stall, PCHold, flush, IFIDFlush, illop, xadr, EPCWrite;
   logic [1:0]  PCSel;
   logic [31:0] EPC;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_hazard_ctrl #(.DRAIN_MAX(DRAIN_MAX)) dut (
      .clk(clk), .reset(reset),
      .IDrs(IDrs), .IDrt(IDrt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
      .IDJr(IDJr), .IDIllegal(IDIllegal), .IDValid(IDValid), .IDPC(IDPC),
      .EXWriteReg(EXWriteReg), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
      .MEMWriteReg(MEMWriteReg), .MEMMemRead(MEMMemRead),
      .EXBranchTaken(EXBranchTaken), .irq(irq),
      .stall(stall), .PCHold(PCHold), .flush(flush), .IFIDFlush(IFIDFlush),
      .illop(illop), .xadr(xadr), .PCSel(PCSel), .EPCWrite(EPCWrite), .EPC(EPC)
   );

   initial forever #5 clk = ~clk;

   // Model state: drain flag/count, pending flag, EPC, last three sampled irq levels.
   bit          m_drain = 1'b0;
   int          m_cnt   = 0;
   bit          m_pend  = 1'b0;
   logic [31:0] m_epc   = 32'd0;
   bit          h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
   bit          e_stall = 1'b0, e_flush = 1'b0, e_ill = 1'b0, e_xadr = 1'b0;
   logic [1:0]  e_sel = 2'b00;
   bit          m_lu, m_jh, m_hz, m_user, m_rise;
   logic [8:0]  exp_vec, act_vec;

   initial forever begin
      @(negedge clk);
      m_lu = EXMemRead && (EXWriteReg != 0) &&
             ((IDUsesRs && EXWriteReg == IDrs) || (IDUsesRt && EXWriteReg == IDrt));
      m_jh = IDJr && (IDrs != 0) &&
             ((EXRegWrite && EXWriteReg == IDrs) || (MEMMemRead && MEMWriteReg == IDrs));
      m_hz   = m_lu || m_jh;
      m_user = IDValid && !IDPC[31];
      e_stall = 0; e_flush = 0; e_ill = 0; e_xadr = 0; e_sel = 2'b00;
      if (!reset) begin
         if (EXBranchTaken) begin
            e_flush = 1; e_sel = 2'b01;
         end else if (!m_drain && IDIllegal && m_user && !m_hz) begin
            e_ill = 1; e_sel = 2'b11;
         end else if (!m_drain && m_pend && m_user && !m_hz) begin
            e_xadr = 1; e_sel = 2'b10;
         end else if (m_hz) begin
            e_stall = 1;
         end
      end
      exp_vec = {e_stall, e_stall, e_flush, e_flush | e_ill | e_xadr, e_ill, e_xadr, e_sel,
                 e_ill | e_xadr};
      act_vec = {stall, PCHold, flush, IFIDFlush, illop, xadr, PCSel, EPCWrite};
      n_cmp++;
      if (act_vec !== exp_vec) begin
         n_bad++;
         $display("FAIL model_ctrl t=%0t: got %b expected %b (stall,hold,flush,ififl,illop,xadr,sel,epcw)",
                  $time, act_vec, exp_vec);
      end
      n_cmp++;
      if (EPC !== m_epc) begin
         n_bad++;
         $display("FAIL model_epc t=%0t: got %h expected %h", $time, EPC, m_epc);
      end
   end

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_drain = 0; m_cnt = 0; m_pend = 0; m_epc = 32'd0;
         h0 = 0; h1 = 0; h2 = 0;
      end else begin
         m_rise = h1 && !h2;
         h2 = h1; h1 = h0; h0 = irq;
         if (e_ill) begin
            m_epc = IDPC + 32'd4; m_drain = 1; m_cnt = 1;
         end else if (e_xadr) begin
            m_epc = IDPC; m_drain = 1; m_cnt = 1;
         end else if (m_drain) begin
            if ((IDValid && IDPC[31]) || m_cnt >= DRAIN_MAX) begin
               m_drain = 0; m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
         m_pend = e_xadr ? 1'b0 : (m_pend | m_rise);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      IDrs = 0; IDrt = 0; IDUsesRs = 0; IDUsesRt = 0; IDJr = 0; IDIllegal = 0;
      IDValid = 1; IDPC = 32'h0040_0000;
      EXWriteReg = 0; EXRegWrite = 0; EXMemRead = 0;
      MEMWriteReg = 0; MEMMemRead = 0; EXBranchTaken = 0; irq = 0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      // Hazard, branch and illegal inputs all active while reset holds everything low
      EXMemRead = 1; EXWriteReg = 8; IDrs = 8; IDUsesRs = 1; EXBranchTaken = 1; IDIllegal = 1;
      tick(); tick();
      mid();
      chk("rst_ctrl", {23'd0, stall, PCHold, flush, IFIDFlush, illop, xadr, PCSel, EPCWrite}, 32'd0);
      chk("rst_epc", EPC, 32'd0);
      tick(); reset = 1'b0; idle();

      // Load-use on rs, then load in MEM, then $0 destination, then rt match
      EXMemRead = 1; EXWriteReg = 8; IDUsesRs = 1; IDrs = 8; IDPC = 32'h0040_0004;
      mid(); chk("lu_stall", {31'd0, stall}, 1); chk("lu_hold", {31'd0, PCHold}, 1);
      tick(); EXMemRead = 0; EXWriteReg = 0; MEMMemRead = 1; MEMWriteReg = 8;
      mid(); chk("lu_one_cycle", {31'd0, stall}, 0);
      tick(); idle(); EXMemRead = 1; EXWriteReg = 0; IDUsesRs = 1; IDrs = 0;
      mid(); chk("lu_r0", {31'd0, stall}, 0);
      tick(); idle(); EXMemRead = 1; EXWriteReg = 9; IDUsesRt = 1; IDrt = 9;
      mid(); chk("lu_rt", {31'd0, stall}, 1);

      // jr behind a load: EX then MEM stall
      tick(); idle(); IDJr = 1; IDUsesRs = 1; IDrs = 5; EXRegWrite = 1; EXWriteReg = 5;
      mid(); chk("jh_ex", {31'd0, stall}, 1);
      tick(); EXRegWrite = 0; EXWriteReg = 0; MEMMemRead = 1; MEMWriteReg = 5;
      mid(); chk("jh_mem", {31'd0, stall}, 1);
      tick(); MEMMemRead = 0;
      mid(); chk("jh_clear", {31'd0, stall}, 0);

      // Branch beats illegal
      tick(); idle(); EXBranchTaken = 1; IDIllegal = 1; IDPC = 32'h0040_0010;
      mid();
      chk("br_flush", {31'd0, flush}, 1); chk("br_ififl", {31'd0, IFIDFlush}, 1);
      chk("br_sel", {30'd0, PCSel}, 1); chk("br_illop", {31'd0, illop}, 0);
      tick(); idle();
      mid(); chk("br_epc", EPC, 32'd0);

      // Illegal entry, repeated illegal during DRAIN ignored
      tick(); IDIllegal = 1; IDPC = 32'h0040_0020;
      mid();
      chk("ill_op", {31'd0, illop}, 1); chk("ill_sel", {30'd0, PCSel}, 3);
      chk("ill_epcw", {31'd0, EPCWrite}, 1);
      tick(); IDPC = 32'd0;
      mid(); chk("ill_rep1", {31'd0, illop}, 0); chk("ill_epc", EPC, 32'h0040_0024);
      tick();
      mid(); chk("ill_rep2", {31'd0, illop}, 0);
      tick(); idle(); IDPC = 32'h8000_0008;
      tick(); idle();

      // Interrupt: irq before E0, xadr between E2 and E3
      tick(); IDPC = 32'h0040_0100; irq = 1;
      tick(); irq = 0;
      mid(); chk("irq_e0", {31'd0, xadr}, 0);
      tick();
      mid(); chk("irq_e1", {31'd0, xadr}, 0);
      tick();
      mid(); chk("irq_xadr", {31'd0, xadr}, 1); chk("irq_sel", {30'd0, PCSel}, 2);
      chk("irq_epcw", {31'd0, EPCWrite}, 1);
      tick(); IDPC = 32'h8000_0040; irq = 1;
      mid(); chk("irq_epc", EPC, 32'h0040_0100); chk("irq_cleared", {31'd0, xadr}, 0);
      tick(); irq = 0;
      for (int i = 0; i < 5; i++) begin
         mid(); chk("irq_kernel_defer", {31'd0, xadr}, 0);
         tick();
      end
      IDPC = 32'h0040_0200;
      mid(); chk("irq_deferred", {31'd0, xadr}, 1);
      tick(); IDPC = 32'h8000_0004;
      mid(); chk("irq2_epc", EPC, 32'h0040_0200);

      // Illegal and pending interrupt together: illop wins, xadr after DRAIN
      tick(); IDPC = 32'h8000_0050; irq = 1;
      tick(); irq = 0;
      tick(); tick(); tick();
      IDPC = 32'h0040_0300; IDIllegal = 1;
      mid(); chk("both_illop", {31'd0, illop}, 1); chk("both_xadr", {31'd0, xadr}, 0);
      tick(); idle(); IDValid = 0; IDPC = 32'd0;
      for (int i = 0; i < DRAIN_MAX; i++) begin
         mid(); chk("both_drain", {31'd0, xadr}, 0);
         tick();
      end
      IDValid = 1; IDPC = 32'h0040_0308;
      mid(); chk("both_xadr_late", {31'd0, xadr}, 1); chk("both_epc_ill", EPC, 32'h0040_0304);
      tick(); IDPC = 32'h8000_0004;
      mid(); chk("both_epc_irq", EPC, 32'h0040_0308);

      // Reset mid-DRAIN with an interrupt pending
      tick(); IDPC = 32'h8000_0060; irq = 1;
      tick(); irq = 0;
      tick(); tick(); tick();
      IDPC = 32'h0040_0400; IDIllegal = 1;
      mid(); chk("rd_illop", {31'd0, illop}, 1);
      tick(); IDPC = 32'h0040_0404; reset = 1'b1;
      mid();
      chk("rd_ctrl", {23'd0, stall, PCHold, flush, IFIDFlush, illop, xadr, PCSel, EPCWrite}, 32'd0);
      chk("rd_epc", EPC, 32'd0);
      tick(); reset = 1'b0; idle(); IDPC = 32'h0040_0404;
      for (int i = 0; i < 4; i++) begin
         mid(); chk("rd_no_xadr", {31'd0, xadr}, 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
